// File: rtl/sbox_ti_sched.sv
// Round-robin front end that shares one 3-share TI AES S-box pipeline among NREQ requesters.
// Optional macro SBOX_TI_SCHED_LFSR_EN: internal 16-bit LFSR replaces the external rnd input.
module sbox_ti_sched #(
  parameter int NREQ = 4,
  parameter int LAT  = 3,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [24*NREQ-1:0]   req_shares,
  output logic [NREQ-1:0]      gnt,
  input  logic [15:0]          rnd,
  output logic [7:0]           sb_in1,
  output logic [7:0]           sb_in2,
  output logic [7:0]           sb_in3,
  output logic [7:0]           sb_r0,
  output logic [7:0]           sb_r1,
  input  logic [7:0]           sb_out1,
  input  logic [7:0]           sb_out2,
  input  logic [7:0]           sb_out3,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [23:0]          rsp_shares,
  output logic                 busy
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] grant_id, scan_idx;
  logic           grant_any;
  logic [23:0]    grant_shares;
  logic [23:0]    sb_in_q, sb_in_d;
  logic [15:0]    sb_r_q, sb_r_d;
  logic [15:0]    rnd_src;
  logic [LAT:0]   tag_v_q, tag_v_d;
  logic [IDW-1:0] tag_id_q [LAT+1];
  logic [IDW-1:0] tag_id_d [LAT+1];

`ifdef SBOX_TI_SCHED_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        unused_rnd;
  assign unused_rnd = ^rnd;
  assign rnd_src    = lfsr_q;

  // Fibonacci x^16+x^14+x^13+x^11+1, shifting right; advances only on issue.
  always_comb begin
    lfsr_d = lfsr_q;
    if (grant_any) lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end
`else
  assign rnd_src = rnd;
`endif

  // NOTE: combinational blocks use blocking '=' with every output defaulted first,
  // so the loop's last write wins and no latch is inferred.
  always_comb begin
    gnt       = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = IDW'((int'(ptr_q) + k) % NREQ);
      if (!rst && !grant_any && req[scan_idx]) begin
        grant_any     = 1'b1;
        grant_id      = scan_idx;
        gnt[scan_idx] = 1'b1;
      end
    end
    grant_shares = req_shares[24*grant_id +: 24];
    ptr_d        = grant_any ? IDW'((int'(grant_id) + 1) % NREQ) : ptr_q;
  end

  // Idle cycles drive zero shares so the S-box never re-evaluates stale data.
  always_comb begin
    sb_in_d     = grant_any ? grant_shares : 24'd0;
    sb_r_d      = grant_any ? rnd_src : sb_r_q;
    tag_v_d     = {tag_v_q[LAT-1:0], grant_any};
    tag_id_d[0] = grant_id;
    for (int s = 1; s <= LAT; s++) tag_id_d[s] = tag_id_q[s-1];
  end

  // NOTE: the tag ids are reset along with the valids so rsp_id reads 0 after
  // reset; sequential state is updated with non-blocking '<=' only.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      sb_in_q <= '0;
      sb_r_q  <= '0;
      tag_v_q <= '0;
      for (int s = 0; s <= LAT; s++) tag_id_q[s] <= '0;
    end else begin
      ptr_q   <= ptr_d;
      sb_in_q <= sb_in_d;
      sb_r_q  <= sb_r_d;
      tag_v_q <= tag_v_d;
      for (int s = 0; s <= LAT; s++) tag_id_q[s] <= tag_id_d[s];
    end
  end

  assign sb_in1     = sb_in_q[23:16];
  assign sb_in2     = sb_in_q[15:8];
  assign sb_in3     = sb_in_q[7:0];
  assign sb_r0      = sb_r_q[15:8];
  assign sb_r1      = sb_r_q[7:0];
  assign rsp_valid  = tag_v_q[LAT];
  assign rsp_id     = tag_id_q[LAT];
  assign rsp_shares = rsp_valid ? {sb_out1, sb_out2, sb_out3} : 24'd0;
  assign busy       = (|req) | (|tag_v_q);

endmodule

// File: tb/tb_sbox_ti_sched.sv
// Self-checking bench for sbox_ti_sched: behavioural S-box pipeline, scoreboard and directed vectors.
module tb_sbox_ti_sched;
  localparam int NREQ = 4;
  localparam int LAT  = 3;
  localparam int IDW  = $clog2(NREQ);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [24*NREQ-1:0] req_shares;
  logic [NREQ-1:0]   gnt;
  logic [15:0]       rnd = 16'h0;
  logic [7:0]        sb_in1, sb_in2, sb_in3, sb_r0, sb_r1;
  logic [7:0]        sb_out1, sb_out2, sb_out3;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [23:0]       rsp_shares;
  logic              busy;
  logic [23:0]       sh [NREQ];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) req_shares[24*i +: 24] = sh[i];
  end

  sbox_ti_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_shares(req_shares), .gnt(gnt), .rnd(rnd),
    .sb_in1(sb_in1), .sb_in2(sb_in2), .sb_in3(sb_in3), .sb_r0(sb_r0), .sb_r1(sb_r1),
    .sb_out1(sb_out1), .sb_out2(sb_out2), .sb_out3(sb_out3),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_shares(rsp_shares), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // AES S-box from first principles: GF(2^8) inverse followed by the affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] aes_sbox(input logic [7:0] a);
    logic [7:0] r = 8'h01, p = a;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    if (a == 8'h00) r = 8'h00;
    return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
  endfunction

  // Behavioural TI S-box: LAT-cycle pipeline with freshly masked output shares.
  logic [23:0] pipe [LAT];
  initial for (int s = 0; s < LAT; s++) pipe[s] = '0;
  always @(posedge clk) begin
    logic [7:0] y;
    y = aes_sbox(sb_in1 ^ sb_in2 ^ sb_in3);
    pipe[0] <= {sb_r0, sb_r1, y ^ sb_r0 ^ sb_r1};
    for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
  end
  assign {sb_out1, sb_out2, sb_out3} = pipe[LAT-1];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    started <= 1'b1;
  end

  // Scoreboard model of the scheduler.
  typedef struct { int due; int id; logic [7:0] sx; } exp_t;
  exp_t        q [$];
  int          m_ptr = 0;
  logic [23:0] m_sb_in = '0;
  logic [15:0] m_r = '0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [7:0]  last_rsp_xor = '0;
  int          last_rsp_id = -1;

  always @(negedge clk) begin
    if (started) begin
      int win;
      logic [NREQ-1:0] exp_gnt;
      bit exp_valid, exp_busy;
      logic [7:0] got_xor;
      win = -1;
      exp_gnt = '0;
      if (!rst) begin
        for (int k = 0; k < NREQ; k++) begin
          if (win < 0 && req[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
        end
      end
      if (win >= 0) exp_gnt[win] = 1'b1;
      check("gnt", 32'(gnt), 32'(exp_gnt));
      check("sb_in", 32'({sb_in1, sb_in2, sb_in3}), 32'(m_sb_in));
      check("sb_r", 32'({sb_r0, sb_r1}), 32'(m_r));
      exp_busy = (|req) || (q.size() > 0);
      check("busy", 32'(busy), 32'(exp_busy));
      exp_valid = (q.size() > 0) && (q[0].due == cyc);
      check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      got_xor = rsp_shares[23:16] ^ rsp_shares[15:8] ^ rsp_shares[7:0];
      if (exp_valid) begin
        check("rsp_id", 32'(rsp_id), 32'(q[0].id));
        check("rsp_xor", 32'(got_xor), 32'(q[0].sx));
        void'(q.pop_front());
      end else begin
        check("rsp_shares_idle", 32'(rsp_shares), 32'd0);
      end
      if (rsp_valid) begin
        last_rsp_xor = got_xor;
        last_rsp_id  = int'(rsp_id);
      end
      if (rst) begin
        m_ptr = 0; m_sb_in = '0; m_r = '0; m_lfsr = 16'hACE1;
        q.delete();
      end else if (win >= 0) begin
        q.push_back('{due: cyc + 1 + LAT, id: win,
                      sx: aes_sbox(sh[win][23:16] ^ sh[win][15:8] ^ sh[win][7:0])});
        m_sb_in = sh[win];
`ifdef SBOX_TI_SCHED_LFSR_EN
        m_r    = m_lfsr;
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`else
        m_r = rnd;
`endif
        m_ptr = (win + 1) % NREQ;
      end else begin
        m_sb_in = '0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rnd = 16'($urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) sh[i] = '0;
    step(2);
    rst = 1'b0;
    step(1);

    // Pin the S-box model itself.
    check("model_sbox_53", 32'(aes_sbox(8'h53)), 32'hED);
    check("model_sbox_00", 32'(aes_sbox(8'h00)), 32'h63);

    // Single request from requester 0.
    sh[0] = 24'h123475; req = 4'b0001; rnd = 16'hBEEF;
    @(negedge clk);
    check("single_gnt", 32'(gnt), 32'h1);
    step(1);
    req = '0;
    @(negedge clk);
    check("single_sb_in1", 32'(sb_in1), 32'h12);
`ifdef SBOX_TI_SCHED_LFSR_EN
    check("lfsr_first_r0", 32'(sb_r0), 32'hAC);
    check("lfsr_first_r1", 32'(sb_r1), 32'hE1);
`else
    check("rnd_r0", 32'(sb_r0), 32'hBE);
    check("rnd_r1", 32'(sb_r1), 32'hEF);
`endif
    step(LAT + 2);
    check("single_rsp_xor", 32'(last_rsp_xor), 32'hED);
    check("single_rsp_id", 32'(last_rsp_id), 32'd0);

    // Zero-share input from requester 1; randomness must hold across idle cycles.
    sh[1] = 24'h000000; req = 4'b0010; rnd = 16'h1234;
    step(1);
    req = '0;
    step(LAT + 2);
    check("zero_rsp_xor", 32'(last_rsp_xor), 32'h63);
    check("zero_rsp_id", 32'(last_rsp_id), 32'd1);
`ifdef SBOX_TI_SCHED_LFSR_EN
    check("lfsr_second_r", 32'({sb_r0, sb_r1}), 32'h5670);
`else
    check("rnd_hold_r", 32'({sb_r0, sb_r1}), 32'h1234);
`endif

    // All four requesting continuously.
    sh[0] = 24'h0A1B2C; sh[1] = 24'hFF0011; sh[2] = 24'h5A5AA5; sh[3] = 24'h010203;
    req = 4'b1111;
    step(8);
    req = '0;
    step(LAT + 3);

    // Fairness wrap: grant 2 so the pointer sits at 3, then 1001 gives 3 then 0.
    req = 4'b0100;
    step(1);
    req = 4'b1001;
    @(negedge clk);
    check("wrap_gnt3", 32'(gnt), 32'h8);
    step(1);
    req = 4'b0001;
    @(negedge clk);
    check("wrap_gnt0", 32'(gnt), 32'h1);
    step(1);
    req = '0;
    step(LAT + 3);

    // Reset mid-flight: three issues, then reset in the following cycle.
    req = 4'b1111;
    step(3);
    req = '0; rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sb", 32'({sb_in1, sb_in2, sb_in3, sb_r0}), 32'd0);
    check("midrst_rsp", 32'(rsp_shares), 32'd0);
    step(LAT + 2);
    req = 4'b1111;
    @(negedge clk);
    check("post_rst_gnt", 32'(gnt), 32'h1);
    step(1);
    req = '0;
    step(LAT + 3);

    // Simultaneous reset and request: reset wins, nothing issued.
    rst = 1'b1; req = 4'b0010;
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    step(1);
    rst = 1'b0; req = '0;
    @(negedge clk);
    check("rst_no_issue", 32'({sb_in1, sb_in2, sb_in3}), 32'd0);
    step(LAT + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sbox_ti_sched.md
# sbox_ti_sched

Round-robin scheduler that shares one threshold-implementation (3-share) AES S-box pipeline among `NREQ` requesters. It accepts 24-bit share triples and issues at most one per cycle into the S-box. It draws fresh 16-bit randomness for the S-box R0/R1 ports on every issue and returns the S-box output shares tagged with the requester ID. It sits between the byte-lane datapath and the `sbox_ti` instance, replacing the serial byte-loading front end used for standalone S-box testing.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8).
- `LAT`, 3, cycles from S-box input ports to valid S-box output shares (≥1).
- `IDW`, `$clog2(NREQ)`, ID width (derived; do not override).

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  per-requester request level.
- `req_shares`  in  24·NREQ  requester i shares at [24i+23:24i] = {in1,in2,in3}.
- `gnt`  out  NREQ  one-hot, combinational, high in the accept cycle.
- `rnd`  in  16  external fresh randomness; ignored when `SBOX_TI_SCHED_LFSR_EN` is defined.
- `sb_in1`, `sb_in2`, `sb_in3`  out  8 each  registered share inputs to the S-box.
- `sb_r0`, `sb_r1`  out  8 each  registered randomness to the S-box.
- `sb_out1`, `sb_out2`, `sb_out3`  in  8 each  S-box output shares.
- `rsp_valid`  out  1  response strobe, one cycle per issued request.
- `rsp_id`  out  IDW  requester index of the response.
- `rsp_shares`  out  24  {sb_out1,sb_out2,sb_out3} when `rsp_valid`=1; 0 otherwise.
- `busy`  out  1  high if any request is pending or any tag is in flight.

## Operation
- **Arbiter.** Round-robin pointer `ptr` (IDW bits, reset 0).
  - In each cycle, grant the first asserted `req[i]` searching from `ptr` upward with wrap.
  - On a grant to i, `ptr` ← (i+1) mod NREQ.
  - No request: `gnt`=0 and `ptr` holds.
- **Requester rule.** Hold `req` high with stable shares until `gnt`. A requester may deassert `req` the cycle after `gnt`, or keep it high to issue again; it is then re-granted only after the others, per round-robin.
- **Issue.** On a grant edge:
  - `sb_in1..3` ← granted shares.
  - `sb_r0`/`sb_r1` ← fresh randomness [15:8]/[7:0].
  - Tag {valid=1, id=i} enters stage 0 of the LAT+1-deep tag shift register.
- **Idle cycles.** `sb_in1..3` ← 0 so that no stale shares are re-evaluated. `sb_r0`/`sb_r1` hold. A valid=0 tag shifts in.
- **Response.** The last tag stage drives `rsp_valid`/`rsp_id`. `rsp_shares` passes `sb_out*` straight through, gated by `rsp_valid`. Responses leave in issue order, and the scheduler never recombines shares.
- **Reset mid-operation.** All tags clear, so in-flight results are dropped and no `rsp_valid` appears for them. `ptr`, `sb_*` and the LFSR return to their reset values.

## Timing
- Reset values:
  - `gnt`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_shares`=0, `busy`=0 (with `req`=0).
  - `sb_in*`=0, `sb_r*`=0.
  - LFSR = 16'hACE1.
- Grant in cycle t puts shares at the S-box ports in cycle t+1. `rsp_valid` is high in cycle t+1+LAT, so latency is LAT+1 cycles.
- Throughput is one issue per cycle. Back-to-back grants give back-to-back responses.
- A simultaneous reset and grant: reset wins, and nothing is issued.
- `busy` = |req OR any tag valid (combinational).

## Configuration
- `SBOX_TI_SCHED_LFSR_EN` defined:
  - Randomness comes from an internal 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, seeded 16'hACE1.
  - The LFSR advances only on issue cycles; the value before advancing is used.
  - `rnd` is unused.
- Not defined: `rnd` is sampled on each issue edge into `sb_r0`/`sb_r1`, and no LFSR exists.

## Test plan
- **Single request.** Reset, then `req`=0001 with shares {0x12,0x34,0x75} (XOR 0x53).
  - Expect `gnt`=0001 for one cycle and `rsp_valid` LAT+1 cycles later with `rsp_id`=0.
  - Expect the XOR of the `rsp_shares` bytes = 0xED.
- **All four requesting continuously.** Each requester presents its own shares.
  - Expect grants 0,1,2,3,0,… one per cycle.
  - Expect `rsp_id` sequence 0,1,2,3 on consecutive cycles, each XOR-correct against the AES S-box model.
- **Fairness wrap.** `ptr`=3 after granting 2, with `req`=1001.
  - Expect a grant to 3, then to 0. Requester 0 is never starved beyond NREQ−1 cycles.
- **Reset mid-flight.** Issue 3 requests, assert `rst` one cycle later for one cycle.
  - Expect no `rsp_valid` afterwards and all outputs 0.
  - Expect the next grant to come from requester 0.
- **Randomness, macro defined.**
  - Expect the first issue `sb_r0`=0xAC, `sb_r1`=0xE1, and new values on each later issue.
  - Expect no change across idle cycles.
- **Randomness, macro undefined.** `rnd`=0xBEEF at the grant.
  - Expect `sb_r0`=0xBE, `sb_r1`=0xEF next cycle, holding while idle.
  - Expect the zero-share input {0x00,0x00,0x00} to return XOR 0x63.
